// File: rtl/dither_pixel_writer_if.sv
// Pixel-stream and frame-memory write bus for the dither pixel writer.
// The master drives pixels and write acknowledges; the slave (the writer) drives ready and the write port.
interface dither_pixel_writer_if #(
  parameter int RGB_SIZE   = 8,
  parameter int ADDR_WIDTH = 16
) ();
  logic                    in_valid;
  logic                    in_ready;
  logic [3*RGB_SIZE-1:0]   in_pixel;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [3*RGB_SIZE-1:0]   mem_wdata;
  logic                    mem_ack;

  modport master (
    output in_valid, in_pixel, mem_ack,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_pixel, mem_ack,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dither_pixel_writer.sv
// Writes dithered pixels in raster order to frame memory, one outstanding write at a time.
// Optional PIXEL_WRITER_CHECKSUM_EN adds a 16-bit per-frame channel-sum checksum output.
module dither_pixel_writer #(
  parameter int IMAGEX           = 256,
  parameter int IMAGEY           = 256,
  parameter int IMAGE_SIZE       = IMAGEX * IMAGEY,
  parameter int IMAGE_ADDR_WIDTH = $clog2(IMAGE_SIZE),
  parameter int IMAGEXlog2       = $clog2(IMAGEX),
  parameter int IMAGEYlog2       = $clog2(IMAGEY),
  parameter int RGB_SIZE         = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  abort_i,
  dither_pixel_writer_if.slave  bus,
  output logic [IMAGEXlog2-1:0] cur_x_o,
  output logic [IMAGEYlog2-1:0] cur_y_o,
  output logic                  busy_o,
  output logic                  frame_done_o
`ifdef PIXEL_WRITER_CHECKSUM_EN
  ,
  output logic [15:0]           checksum_o
`endif
);

  localparam int PIX_W = 3 * RGB_SIZE;
  localparam logic [IMAGE_ADDR_WIDTH-1:0] LAST_ADDR = IMAGE_ADDR_WIDTH'(IMAGE_SIZE - 1);
  localparam logic [IMAGEXlog2-1:0]       LAST_X    = IMAGEXlog2'(IMAGEX - 1);

  typedef enum logic [1:0] {IDLE, RUN, WRITE, DONE} state_e;

  state_e                      state_q, state_d;
  logic                        mem_we_q, mem_we_d;
  logic [IMAGE_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [PIX_W-1:0]            mem_wdata_q, mem_wdata_d;
  logic [IMAGEXlog2-1:0]       cur_x_q, cur_x_d;
  logic [IMAGEYlog2-1:0]       cur_y_q, cur_y_d;
`ifdef PIXEL_WRITER_CHECKSUM_EN
  logic [15:0]                 csum_q, csum_d;
`endif

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path through the case can infer a latch.
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
`ifdef PIXEL_WRITER_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    // Abort wins over the handshake and the acknowledge; position and checksum are kept.
    if (abort_i) begin
      state_d  = IDLE;
      mem_we_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d    = RUN;
            mem_addr_d = '0;
            cur_x_d    = '0;
            cur_y_d    = '0;
`ifdef PIXEL_WRITER_CHECKSUM_EN
            csum_d     = '0;
`endif
          end
        end
        RUN: begin
          if (bus.in_valid) begin
            mem_wdata_d = bus.in_pixel;
            mem_we_d    = 1'b1;
            state_d     = WRITE;
          end
        end
        WRITE: begin
          if (bus.mem_ack) begin
            mem_we_d = 1'b0;
`ifdef PIXEL_WRITER_CHECKSUM_EN
            csum_d = csum_q
                   + 16'(mem_wdata_q[2*RGB_SIZE +: RGB_SIZE])
                   + 16'(mem_wdata_q[RGB_SIZE   +: RGB_SIZE])
                   + 16'(mem_wdata_q[0          +: RGB_SIZE]);
`endif
            // The last pixel leaves address and coordinates parked on the frame's final position.
            if (mem_addr_q == LAST_ADDR) begin
              state_d = DONE;
            end else begin
              state_d    = RUN;
              mem_addr_d = mem_addr_q + IMAGE_ADDR_WIDTH'(1);
              if (cur_x_q == LAST_X) begin
                cur_x_d = '0;
                cur_y_d = cur_y_q + IMAGEYlog2'(1);
              end else begin
                cur_x_d = cur_x_q + IMAGEXlog2'(1);
              end
            end
          end
        end
        DONE: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every register samples the pre-edge values computed above.
    if (rst) begin
      state_q     <= IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
`ifdef PIXEL_WRITER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
`ifdef PIXEL_WRITER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == RUN);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cur_x_o       = cur_x_q;
  assign cur_y_o       = cur_y_q;
  assign busy_o        = (state_q == RUN) || (state_q == WRITE);
  assign frame_done_o  = (state_q == DONE);
`ifdef PIXEL_WRITER_CHECKSUM_EN
  assign checksum_o    = csum_q;
`endif

endmodule

// File: tb/tb_dither_pixel_writer.sv
// Directed bench for dither_pixel_writer on a 4x2 frame: raster writes, backpressure, gaps, abort, ignored events, reset.
// With PIXEL_WRITER_CHECKSUM_EN a second 12x8 instance checks checksum wrap.
module tb_dither_pixel_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i;
  logic       abort_i;
  logic [1:0] cur_x;
  logic [0:0] cur_y;
  logic       busy;
  logic       frame_done;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  dither_pixel_writer_if #(.RGB_SIZE(8), .ADDR_WIDTH(3)) bus ();

`ifdef PIXEL_WRITER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  dither_pixel_writer #(.IMAGEX(4), .IMAGEY(2), .RGB_SIZE(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .bus          (bus),
    .cur_x_o      (cur_x),
    .cur_y_o      (cur_y),
    .busy_o       (busy),
    .frame_done_o (frame_done)
`ifdef PIXEL_WRITER_CHECKSUM_EN
    ,
    .checksum_o   (checksum)
`endif
  );

`ifdef PIXEL_WRITER_CHECKSUM_EN
  dither_pixel_writer_if #(.RGB_SIZE(8), .ADDR_WIDTH(7)) bus2 ();
  logic        start2;
  logic        abort2;
  logic [3:0]  cur_x2;
  logic [2:0]  cur_y2;
  logic        busy2;
  logic        frame_done2;
  logic [15:0] checksum2;

  dither_pixel_writer #(.IMAGEX(12), .IMAGEY(8), .RGB_SIZE(8)) dut2 (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start2),
    .abort_i      (abort2),
    .bus          (bus2),
    .cur_x_o      (cur_x2),
    .cur_y_o      (cur_y2),
    .busy_o       (busy2),
    .frame_done_o (frame_done2),
    .checksum_o   (checksum2)
  );
`endif

  typedef struct {
    logic [2:0]  addr;
    logic [23:0] data;
  } wr_t;

  wr_t wq[$];
  int  done_cnt;

  // Completed writes and frame_done pulses, observed mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_we && bus.mem_ack && !abort_i) wq.push_back('{bus.mem_addr, bus.mem_wdata});
      if (frame_done) done_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One 8-pixel frame. stall_at/abort_at/poke_at select the pixel that gets the special treatment (-1 = none).
  task automatic send_frame(input string nm, input int stall_at, input int stall_n, input bit gaps,
                            input int abort_at, input int poke_at, input bit ones);
    logic [23:0] pix;
    logic [15:0] exp_sum;
    int          to;
    wq.delete();
    done_cnt = 0;
    exp_sum  = '0;
    start_i  = 1'b1;
    step();
    start_i  = 1'b0;
    check({nm, ":start_ready"}, bus.in_ready, 1);
    check({nm, ":start_addr"}, bus.mem_addr, 0);
    for (int p = 0; p < 8; p++) begin
      pix = ones ? 24'hFFFFFF : 24'(p + 1);
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) step();
        check({nm, ":gap_ready"}, bus.in_ready, 1);
        check({nm, ":gap_we"}, bus.mem_we, 0);
      end
      if (p == poke_at) begin
        bus.in_valid = 1'b0;
        start_i      = 1'b1;
        bus.mem_ack  = 1'b1;
        step();
        start_i      = 1'b0;
        bus.mem_ack  = 1'b0;
        check({nm, ":poke_busy"}, busy, 1);
        check({nm, ":poke_ready"}, bus.in_ready, 1);
        check({nm, ":poke_we"}, bus.mem_we, 0);
        check({nm, ":poke_addr"}, bus.mem_addr, p);
      end
      bus.in_valid = 1'b1;
      bus.in_pixel = pix;
      to = 0;
      while (!bus.in_ready && to < 20) begin
        step();
        to++;
      end
      check({nm, ":wait_ready"}, bus.in_ready, 1);
      step();
      check({nm, ":we"}, bus.mem_we, 1);
      check({nm, ":addr"}, bus.mem_addr, p);
      check({nm, ":wdata"}, bus.mem_wdata, pix);
      check({nm, ":wr_ready"}, bus.in_ready, 0);
      check({nm, ":cur_x"}, cur_x, p % 4);
      check({nm, ":cur_y"}, cur_y, p / 4);
      if (p == stall_at) begin
        for (int s = 0; s < stall_n; s++) begin
          bus.in_pixel = 24'hBADBAD;
          step();
          check({nm, ":stall_we"}, bus.mem_we, 1);
          check({nm, ":stall_addr"}, bus.mem_addr, p);
          check({nm, ":stall_wdata"}, bus.mem_wdata, pix);
          check({nm, ":stall_ready"}, bus.in_ready, 0);
        end
      end
      if (p == abort_at) begin
        bus.mem_ack = 1'b1;
        abort_i     = 1'b1;
        step();
        bus.mem_ack  = 1'b0;
        abort_i      = 1'b0;
        bus.in_valid = 1'b0;
        check({nm, ":abort_busy"}, busy, 0);
        check({nm, ":abort_we"}, bus.mem_we, 0);
        check({nm, ":abort_done"}, frame_done, 0);
        check({nm, ":abort_addr"}, bus.mem_addr, p);
        check({nm, ":abort_ready"}, bus.in_ready, 0);
        step();
        check({nm, ":abort_no_done"}, done_cnt, 0);
        check({nm, ":abort_nwr"}, wq.size(), p);
        return;
      end
      exp_sum = exp_sum + 16'(pix[23:16]) + 16'(pix[15:8]) + 16'(pix[7:0]);
      bus.mem_ack = 1'b1;
      step();
      bus.mem_ack = 1'b0;
      check({nm, ":ack_we"}, bus.mem_we, 0);
      if (p < 7) check({nm, ":ack_done"}, frame_done, 0);
    end
    bus.in_valid = 1'b0;
    check({nm, ":done"}, frame_done, 1);
    check({nm, ":done_busy"}, busy, 0);
    check({nm, ":done_addr"}, bus.mem_addr, 7);
    check({nm, ":done_x"}, cur_x, 3);
    check({nm, ":done_y"}, cur_y, 1);
`ifdef PIXEL_WRITER_CHECKSUM_EN
    check({nm, ":csum"}, checksum, exp_sum);
`endif
    step();
    check({nm, ":post_done"}, frame_done, 0);
    check({nm, ":post_ready"}, bus.in_ready, 0);
    check({nm, ":post_addr"}, bus.mem_addr, 7);
    check({nm, ":pulses"}, done_cnt, 1);
    check({nm, ":nwr"}, wq.size(), 8);
    for (int i = 0; i < wq.size(); i++) begin
      check({nm, ":wr_addr"}, wq[i].addr, i);
      check({nm, ":wr_data"}, wq[i].data, ones ? 24'hFFFFFF : 24'(i + 1));
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    start_i      = 1'b0;
    abort_i      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_pixel = '0;
    bus.mem_ack  = 1'b0;
`ifdef PIXEL_WRITER_CHECKSUM_EN
    start2        = 1'b0;
    abort2        = 1'b0;
    bus2.in_valid = 1'b0;
    bus2.in_pixel = '0;
    bus2.mem_ack  = 1'b0;
`endif
    repeat (3) step();
    check("rst:ready", bus.in_ready, 0);
    check("rst:we", bus.mem_we, 0);
    check("rst:addr", bus.mem_addr, 0);
    check("rst:wdata", bus.mem_wdata, 0);
    check("rst:xy", {cur_x, cur_y}, 0);
    check("rst:busy", busy, 0);
    check("rst:done", frame_done, 0);
    rst = 1'b0;
    step();

    send_frame("basic", -1, 0, 1'b0, -1, -1, 1'b0);
    send_frame("stall", 2, 3, 1'b0, -1, -1, 1'b0);
    send_frame("gaps", -1, 0, 1'b1, -1, -1, 1'b0);
    send_frame("abort", -1, 0, 1'b0, 5, -1, 1'b0);
    send_frame("reframe", -1, 0, 1'b0, -1, -1, 1'b0);
    send_frame("ignore", -1, 0, 1'b0, -1, 2, 1'b0);
    send_frame("ones", -1, 0, 1'b0, -1, -1, 1'b1);

    // Reset while the second write of a frame is outstanding.
    start_i = 1'b1; step(); start_i = 1'b0;
    bus.in_valid = 1'b1; bus.in_pixel = 24'h123456; step();
    bus.mem_ack = 1'b1; step(); bus.mem_ack = 1'b0;
    step();
    check("midrst:pre_addr", bus.mem_addr, 1);
    bus.in_valid = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    check("midrst:we", bus.mem_we, 0);
    check("midrst:addr", bus.mem_addr, 0);
    check("midrst:wdata", bus.mem_wdata, 0);
    check("midrst:x", cur_x, 0);
    check("midrst:busy", busy, 0);
`ifdef PIXEL_WRITER_CHECKSUM_EN
    check("midrst:csum", checksum, 0);

    // 96 pixels of 0xFFFFFF: 96*765 = 73440 wraps to 0x1EE0.
    start2 = 1'b1; step(); start2 = 1'b0;
    for (int p = 0; p < 96; p++) begin
      int to2;
      bus2.in_valid = 1'b1;
      bus2.in_pixel = 24'hFFFFFF;
      to2 = 0;
      while (!bus2.in_ready && to2 < 20) begin
        step();
        to2++;
      end
      if (to2 >= 20) check("big:wait_ready", bus2.in_ready, 1);
      step();
      bus2.mem_ack = 1'b1;
      step();
      bus2.mem_ack = 1'b0;
    end
    bus2.in_valid = 1'b0;
    check("big:done", frame_done2, 1);
    check("big:csum", checksum2, 16'h1EE0);
    check("big:addr", bus2.mem_addr, 95);
    check("big:xy", {cur_x2, cur_y2}, {4'd11, 3'd7});
    step();
    check("big:csum_hold", checksum2, 16'h1EE0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
